// File: rtl/main_mem.sv
// Block-transfer main memory behind the cache bus arbiter: accepts one block per
// transaction as multi-beat writes or reads, with modelled read latency and write recovery.
module main_mem #(
  parameter int block_width_p    = 8,
  parameter int dma_data_width_p = 2,
  parameter int mem_words_p      = 1024,
  parameter int rd_latency_p     = 4,
  parameter int wr_latency_p     = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  input  logic                          mem_we_i,
  input  logic [31:0]                   mem_addr_i,
  input  logic [dma_data_width_p*32-1:0] mem_wdata_i,
  output logic                          mem_valid_o,
  output logic [dma_data_width_p*32-1:0] mem_data_o
);

  localparam int nbeats_lp  = block_width_p / dma_data_width_p;
  localparam int aw_lp      = $clog2(mem_words_p);
  localparam int cw_lp      = $clog2(nbeats_lp + 1);
  localparam int lat_max_lp = (rd_latency_p > wr_latency_p) ? rd_latency_p : wr_latency_p;
  localparam int lw_lp      = $clog2(lat_max_lp + 1);
  localparam int dw_lp      = dma_data_width_p * 32;

  localparam logic [aw_lp-1:0] blk_mask_lp  = aw_lp'(block_width_p - 1);
  localparam logic [aw_lp-1:0] beat_step_lp = aw_lp'(dma_data_width_p);
  localparam logic [cw_lp-1:0] last_beat_lp = cw_lp'(nbeats_lp - 1);
  localparam logic [cw_lp-1:0] nbeats_c_lp  = cw_lp'(nbeats_lp);
  localparam logic [lw_lp-1:0] rd_wait_lp   = lw_lp'(rd_latency_p - 1);
  localparam logic [lw_lp-1:0] wr_busy_lp   = lw_lp'(wr_latency_p);
  localparam logic [lw_lp-1:0] lat_one_lp   = lw_lp'(1);

  typedef enum logic [2:0] {IDLE, WR, WR_BUSY, RD_WAIT, RD_DATA} state_e;

  logic [31:0] mem_r [mem_words_p];

  state_e            state_q, state_d;
  logic [aw_lp-1:0]  base_q, base_d;
  logic [cw_lp-1:0]  cnt_q, cnt_d;
  logic [lw_lp-1:0]  lat_q, lat_d;
  logic              valid_q, valid_d;
  logic [dw_lp-1:0]  data_q, data_d;

  logic              hs;
  logic [aw_lp-1:0]  req_base;
  logic              wr_en;
  logic [aw_lp-1:0]  wr_base, wr_addr;
  logic [cw_lp-1:0]  wr_beat;
  logic              rd_load;
  logic [aw_lp-1:0]  rd_base, rd_addr;
  logic [cw_lp-1:0]  rd_beat;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{mem_addr_i[31:aw_lp+2], mem_addr_i[1:0]};
  assign req_base    = mem_addr_i[aw_lp+1:2] & ~blk_mask_lp;
  assign mem_ready_o = (state_q == IDLE) || (state_q == WR);
  assign hs          = mem_valid_i && mem_ready_o && !reset_i;
  assign wr_addr     = wr_base + aw_lp'(wr_beat) * beat_step_lp;
  assign rd_addr     = rd_base + aw_lp'(rd_beat) * beat_step_lp;
  assign mem_valid_o = valid_q;
  assign mem_data_o  = data_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    valid_d = 1'b0;
    data_d  = '0;
    wr_en   = 1'b0;
    wr_base = base_q;
    wr_beat = cnt_q;
    rd_load = 1'b0;
    rd_base = base_q;
    rd_beat = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          base_d = req_base;
          if (mem_we_i) begin
            wr_en   = 1'b1;
            wr_base = req_base;
            wr_beat = '0;
            cnt_d   = cw_lp'(1);
            lat_d   = wr_busy_lp;
            if (nbeats_lp > 1)        state_d = WR;
            else if (wr_latency_p > 0) state_d = WR_BUSY;
            else                      state_d = IDLE;
          end else begin
            lat_d = rd_wait_lp;
            cnt_d = '0;
            if (rd_latency_p == 1) begin
              // Single-cycle latency: first beat is registered on the acceptance edge.
              state_d = RD_DATA;
              rd_load = 1'b1;
              rd_base = req_base;
              rd_beat = '0;
              cnt_d   = cw_lp'(1);
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      WR: begin
        if (hs) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + cw_lp'(1);
          if (cnt_q == last_beat_lp) begin
            cnt_d   = '0;
            lat_d   = wr_busy_lp;
            state_d = (wr_latency_p > 0) ? WR_BUSY : IDLE;
          end
        end
      end
      WR_BUSY: begin
        if (lat_q <= lat_one_lp) state_d = IDLE;
        else                     lat_d   = lat_q - lat_one_lp;
      end
      RD_WAIT: begin
        if (lat_q <= lat_one_lp) begin
          state_d = RD_DATA;
          rd_load = 1'b1;
          rd_beat = '0;
          cnt_d   = cw_lp'(1);
        end else begin
          lat_d = lat_q - lat_one_lp;
        end
      end
      RD_DATA: begin
        // cnt_q names the next beat to present; the current one is already in data_q.
        if (cnt_q == nbeats_c_lp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rd_load = 1'b1;
          cnt_d   = cnt_q + cw_lp'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_load) begin
      valid_d = 1'b1;
      for (int j = 0; j < dma_data_width_p; j++)
        data_d[32*j +: 32] = mem_r[rd_addr + aw_lp'(j)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int j = 0; j < dma_data_width_p; j++)
        mem_r[wr_addr + aw_lp'(j)] <= mem_wdata_i[32*j +: 32];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_main_mem.sv
// Bench for main_mem: two instances (default latencies, and rd=1/wr=0), directed vectors,
// reset corner cases and random block traffic against a word-array reference model.
module tb_main_mem;

  logic        clk;
  logic        rst  [2];
  logic        vi   [2];
  logic        rdy  [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [63:0] wd   [2];
  logic        vo   [2];
  logic [63:0] dato [2];

  int checks = 0;
  int errors = 0;
  int rdlat [2] = '{4, 1};
  int wrlat [2] = '{2, 0};
  logic [31:0] model   [2][1024];
  bit          written [2][128];

  main_mem dut0 (
    .clk_i(clk), .reset_i(rst[0]), .mem_valid_i(vi[0]), .mem_ready_o(rdy[0]),
    .mem_we_i(we[0]), .mem_addr_i(addr[0]), .mem_wdata_i(wd[0]),
    .mem_valid_o(vo[0]), .mem_data_o(dato[0])
  );

  main_mem #(.rd_latency_p(1), .wr_latency_p(0)) dut1 (
    .clk_i(clk), .reset_i(rst[1]), .mem_valid_i(vi[1]), .mem_ready_o(rdy[1]),
    .mem_we_i(we[1]), .mem_addr_i(addr[1]), .mem_wdata_i(wd[1]),
    .mem_valid_o(vo[1]), .mem_data_o(dato[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          id;
    logic [31:0] wa;
    logic [31:0] ra;
    logic [31:0] base;
    int          gap_beat;
    int          gap_len;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int blk_base(input logic [31:0] a);
    return (int'((a >> 2) % 1024)) & ~7;
  endfunction

  task automatic wait_ready(input int id);
    int n = 0;
    while (!rdy[id] && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", {63'b0, rdy[id]}, 64'd1);
  endtask

  task automatic wr_block(input int id, input logic [31:0] a, input logic [31:0] w [8],
                          input int gap_beat, input int gap_len, input int nsend);
    int base = blk_base(a);
    int n;
    wait_ready(id);
    for (int b = 0; b < nsend; b++) begin
      if (b == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          vi[id] = 1'b0;
          tick();
          chk("gap_ready", {63'b0, rdy[id]}, 64'd1);
        end
      end
      vi[id]   = 1'b1;
      we[id]   = (b == 0) ? 1'b1 : 1'($urandom);
      addr[id] = (b == 0) ? a : $urandom;
      wd[id]   = {w[2*b+1], w[2*b]};
      chk("wr_beat_ready", {63'b0, rdy[id]}, 64'd1);
      tick();
      model[id][base + 2*b]     = w[2*b];
      model[id][base + 2*b + 1] = w[2*b+1];
    end
    vi[id] = 1'b0;
    we[id] = 1'($urandom);
    if (nsend == 4) begin
      written[id][base/8] = 1'b1;
      n = 0;
      while (!rdy[id] && n < 20) begin
        tick();
        n++;
      end
      chk("wr_busy_cycles", 64'(n), 64'(wrlat[id]));
    end
  endtask

  task automatic rd_block(input int id, input logic [31:0] a, input int reset_at,
                          output logic [63:0] beats [4]);
    int n;
    for (int k = 0; k < 4; k++) beats[k] = '0;
    wait_ready(id);
    vi[id] = 1'b1;
    we[id] = 1'b0;
    addr[id] = a;
    tick();
    vi[id] = 1'b0;
    addr[id] = $urandom;
    n = 1;
    while (!vo[id] && n < 20) begin
      chk("rd_wait_data_zero", dato[id], 64'd0);
      tick();
      n++;
    end
    chk("rd_latency", 64'(n), 64'(rdlat[id]));
    for (int k = 0; k < 4; k++) begin
      if (k == reset_at) begin
        rst[id] = 1'b1;
        #1;
        chk("rst_valid", {63'b0, vo[id]}, 64'd0);
        chk("rst_ready", {63'b0, rdy[id]}, 64'd1);
        chk("rst_data", dato[id], 64'd0);
        @(negedge clk);
        rst[id] = 1'b0;
        tick();
        return;
      end
      chk("rd_valid", {63'b0, vo[id]}, 64'd1);
      chk("rd_ready_low", {63'b0, rdy[id]}, 64'd0);
      beats[k] = dato[id];
      tick();
    end
    chk("rd_end_valid", {63'b0, vo[id]}, 64'd0);
    chk("rd_end_data", dato[id], 64'd0);
    chk("rd_end_ready", {63'b0, rdy[id]}, 64'd1);
  endtask

  task automatic chk_model(input int id, input logic [31:0] a, input logic [63:0] beats [4]);
    int base = blk_base(a);
    for (int k = 0; k < 4; k++)
      chk("model_beat", beats[k], {model[id][base + 2*k + 1], model[id][base + 2*k]});
  endtask

  initial begin
    vec_t        vecs [6];
    logic [31:0] w [8];
    logic [63:0] beats [4];
    int          id, blk;
    logic [31:0] a;

    vecs[0] = '{0, 32'h0000_0040, 32'h0000_0040, 32'h100, -1, 0};
    vecs[1] = '{0, 32'h0000_0040, 32'h0000_005C, 32'h200,  2, 3};
    vecs[2] = '{0, 32'h0000_1040, 32'h0000_0040, 32'h300, -1, 0};
    vecs[3] = '{1, 32'h0000_0080, 32'h0000_009F, 32'h400, -1, 0};
    vecs[4] = '{1, 32'hFFFF_FFE0, 32'h0000_0FE0, 32'h500,  1, 2};
    vecs[5] = '{1, 32'h0000_1040, 32'h0000_0044, 32'h600, -1, 0};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vi[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_valid", {63'b0, vo[i]}, 64'd0);
      chk("reset_data", dato[i], 64'd0);
      chk("reset_ready", {63'b0, rdy[i]}, 64'd1);
    end
    // Handshakes during reset must be ignored.
    vi[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40;
    repeat (3) tick();
    chk("reset_ignores_req", {63'b0, vo[0]}, 64'd0);
    vi[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) w[i] = vecs[v].base + 32'(i);
      wr_block(vecs[v].id, vecs[v].wa, w, vecs[v].gap_beat, vecs[v].gap_len, 4);
      rd_block(vecs[v].id, vecs[v].ra, -1, beats);
      for (int k = 0; k < 4; k++)
        chk("vec_beat", beats[k], {vecs[v].base + 32'(2*k + 1), vecs[v].base + 32'(2*k)});
    end

    // Reset during the second read beat, then a clean read of the same block.
    for (int i = 0; i < 2; i++) begin
      rd_block(i, 32'h40, 1, beats);
      chk("rst_beat0", beats[0], (i == 0) ? {32'h301, 32'h300} : {32'h601, 32'h600});
      rd_block(i, 32'h40, -1, beats);
      chk_model(i, 32'h40, beats);
    end

    // Reset after write beat 1: beats 0-1 take new data, beats 2-3 keep the old block.
    for (int i = 0; i < 8; i++) w[i] = 32'h700 + 32'(i);
    wr_block(0, 32'h100, w, -1, 0, 4);
    for (int i = 0; i < 8; i++) w[i] = 32'h800 + 32'(i);
    wr_block(0, 32'h100, w, -1, 0, 2);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    tick();
    rd_block(0, 32'h104, -1, beats);
    chk("partial_b0", beats[0], {32'h801, 32'h800});
    chk("partial_b1", beats[1], {32'h803, 32'h802});
    chk("partial_b2", beats[2], {32'h705, 32'h704});
    chk("partial_b3", beats[3], {32'h707, 32'h706});

    for (int it = 0; it < 60; it++) begin
      id  = int'($urandom_range(0, 1));
      blk = int'($urandom_range(0, 127));
      a   = (32'($urandom_range(0, 7)) << 12) | (32'(blk) << 5) | 32'($urandom_range(0, 31));
      if (!written[id][blk] || ($urandom_range(0, 1) == 1)) begin
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        wr_block(id, a, w, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 4);
      end else begin
        rd_block(id, a, -1, beats);
        chk_model(id, a, beats);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
